// File: rtl/seq_detect_prog_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    FILL     = 2'd1,
    HUNT     = 2'd2
  } state_e;

  // A pattern length is usable when it is at least one bit and fits the pattern register.
  function automatic logic len_legal(input int unsigned len, input int unsigned max);
    return (len >= 1) && (len <= max);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Configuration, serial input and status signals of the pattern detector.
interface seq_detect_prog_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = DEF_CNT_W
) ();

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  dout, match_count, armed, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output dout, match_count, armed, cfg_err
  );

endinterface

// File: rtl/seq_detect_prog_match_cnt.sv
// Saturating match counter with synchronous clear.
module seq_match_cnt
  import seq_detect_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; increment holds once the counter is all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with overlap control
// and a saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  seq_detect_prog_if.slave bus
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               dout_q, dout_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic               match;
  logic               hit;
  logic               cnt_clr;

  // Compare window: the stored history with the incoming bit appended,
  // masked down to the programmed length.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    window = {hist_q, bus.din};
    match  = (((window ^ pat_q) & mask) == '0);
  end

  // Next-state and datapath updates; cfg_load overrides any data bit.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;
    hit       = 1'b0;
    cnt_clr   = 1'b0;

    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pattern;
      len_d   = bus.cfg_len;
      ovl_d   = bus.cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      cnt_clr = 1'b1;
      if (len_legal(32'(bus.cfg_len), MAX_LEN)) begin
        state_d = FILL;
      end else begin
        state_d   = DISARMED;
        cfg_err_d = 1'b1;
      end
    end else if (bus.din_valid) begin
      unique case (state_q)
        DISARMED: begin
          state_d = DISARMED;
        end
        FILL: begin
          hist_d = window[MAX_LEN-2:0];
          // The bit that completes the fill is compared immediately.
          if (fill_q == (len_q - LEN_W'(1))) begin
            hit = match;
            if (match && !ovl_q) begin
              state_d = FILL;
              fill_d  = '0;
            end else begin
              state_d = HUNT;
            end
          end else begin
            fill_d = fill_q + LEN_W'(1);
          end
        end
        HUNT: begin
          hist_d = window[MAX_LEN-2:0];
          hit    = match;
          if (match && !ovl_q) begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = DISARMED;
        end
      endcase
    end

    dout_d = hit;
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= DISARMED;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  seq_match_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (hit),
    .count   (bus.match_count)
  );

  assign bus.dout    = dout_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.armed   = (state_q != DISARMED);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a default-width instance and a 4-bit
// counter instance share the same stimulus.
module tb_seq_detect_prog;

  logic       clock;
  logic       reset_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;

  int unsigned total;
  int unsigned bad;

  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(16)) bus_a ();
  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(4))  bus_b ();

  assign bus_a.cfg_load    = cfg_load;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len     = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap;
  assign bus_a.din_valid   = din_valid;
  assign bus_a.din         = din;
  assign bus_b.cfg_load    = cfg_load;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len     = cfg_len;
  assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_b.din_valid   = din_valid;
  assign bus_b.din         = din;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(16)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(4)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_dout(input string tag, input logic exp);
    chk({tag, "_a"}, 32'(bus_a.dout), 32'(exp));
    chk({tag, "_b"}, 32'(bus_b.dout), 32'(exp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dout_a"},  32'(bus_a.dout), 0);
    chk({tag, "_cnt_a"},   32'(bus_a.match_count), 0);
    chk({tag, "_armed_a"}, 32'(bus_a.armed), 0);
    chk({tag, "_err_a"},   32'(bus_a.cfg_err), 0);
    chk({tag, "_dout_b"},  32'(bus_b.dout), 0);
    chk({tag, "_cnt_b"},   32'(bus_b.match_count), 0);
    chk({tag, "_armed_b"}, 32'(bus_b.armed), 0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    step();
    cfg_load    = 1'b0;
    cfg_pattern = 8'hA5;
    cfg_len     = 4'd7;
    cfg_overlap = ~ovl;
  endtask

  task automatic send(input string tag, input logic b, input logic exp);
    din_valid = 1'b1;
    din       = b;
    step();
    din_valid = 1'b0;
    din       = 1'b0;
    chk_dout(tag, exp);
  endtask

  // Bits go out MSB first (bit n-1 first in time); exps is aligned the same way.
  task automatic send_seq(input string tag, input logic [15:0] bits,
                          input logic [15:0] exps, input int unsigned n);
    logic [15:0] b;
    logic [15:0] e;
    b = bits;
    e = exps;
    for (int unsigned i = n; i > 0; i--) begin
      send(tag, b[i-1], e[i-1]);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    din_valid   = 1'b0;
    din         = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // Non-overlapping 1010: only the first completion counts.
    load(8'b0000_1010, 4'd4, 1'b0);
    chk("basic_armed", 32'(bus_a.armed), 1);
    chk("basic_err", 32'(bus_a.cfg_err), 0);
    chk("basic_cnt0", 32'(bus_a.match_count), 0);
    send_seq("basic", 16'b10_1010, 16'b00_0100, 6);
    chk("basic_cnt", 32'(bus_a.match_count), 1);
    step();
    chk_dout("basic_idle", 1'b0);

    // Overlapping 1010: completions on bits 4 and 6.
    load(8'b0000_1010, 4'd4, 1'b1);
    chk("ovl_cnt0", 32'(bus_a.match_count), 0);
    send_seq("ovl", 16'b10_1010, 16'b00_0101, 6);
    chk("ovl_cnt", 32'(bus_a.match_count), 2);

    // 110 with five idle cycles between bits.
    load(8'b0000_0110, 4'd3, 1'b0);
    send("gap_b1", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin step(); chk_dout("gap1", 1'b0); end
    send("gap_b2", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin step(); chk_dout("gap2", 1'b0); end
    send("gap_b3", 1'b0, 1'b1);
    step();
    chk_dout("gap_after", 1'b0);
    chk("gap_cnt", 32'(bus_a.match_count), 1);

    // Illegal length 0.
    load(8'b0000_0001, 4'd0, 1'b1);
    chk("len0_err", 32'(bus_a.cfg_err), 1);
    chk("len0_armed", 32'(bus_a.armed), 0);
    chk("len0_cnt", 32'(bus_a.match_count), 0);
    step();
    chk("len0_err_pulse", 32'(bus_a.cfg_err), 0);
    send_seq("len0", 16'b1111, 16'b0000, 4);
    chk("len0_cnt_end", 32'(bus_a.match_count), 0);

    // Illegal length 9.
    load(8'b0000_0001, 4'd9, 1'b1);
    chk("len9_err", 32'(bus_a.cfg_err), 1);
    chk("len9_armed", 32'(bus_a.armed), 0);
    step();
    chk("len9_err_pulse", 32'(bus_a.cfg_err), 0);
    send_seq("len9", 16'b1011, 16'b0000, 4);
    chk("len9_cnt", 32'(bus_a.match_count), 0);

    // Reload coinciding with the completing bit drops that bit.
    load(8'b0000_1010, 4'd4, 1'b1);
    send_seq("prio", 16'b101, 16'b000, 3);
    cfg_load    = 1'b1;
    cfg_pattern = 8'b0000_1010;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    din_valid   = 1'b1;
    din         = 1'b0;
    step();
    cfg_load  = 1'b0;
    din_valid = 1'b0;
    chk_dout("prio_drop", 1'b0);
    chk("prio_cnt", 32'(bus_a.match_count), 0);
    chk("prio_armed", 32'(bus_a.armed), 1);
    send("prio_next", 1'b0, 1'b0);
    chk("prio_cnt2", 32'(bus_a.match_count), 0);

    // Length 1, pattern 1, overlap: every 1 matches; 4-bit counter saturates.
    load(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send("sat", 1'b1, 1'b1);
      if (i == 14) chk("sat_cnt_b15", 32'(bus_b.match_count), 15);
    end
    chk("sat_cnt_b", 32'(bus_b.match_count), 15);
    chk("sat_cnt_a", 32'(bus_a.match_count), 20);

    // Reset mid-stream clears everything and disarms.
    din_valid = 1'b1;
    din       = 1'b1;
    reset_n   = 1'b0;
    step();
    din_valid = 1'b0;
    chk_idle_outputs("midrst");
    reset_n = 1'b1;
    send("midrst_bit", 1'b1, 1'b0);
    chk("midrst_armed", 32'(bus_a.armed), 0);

    // Full-length pattern after seven non-matching bits.
    load(8'b1011_0011, 4'd8, 1'b0);
    send_seq("maxlen", 16'b000_0000_1011_0011, 16'b000_0000_0000_0001, 15);
    chk("maxlen_cnt", 32'(bus_a.match_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
